// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin select generator for a 4:1 bit mux with per-grant burst limit and valid/ready handshake.
// Arbitration takes one cycle (req in N -> sel/busy in N+1); sel is frozen while a grant is active, and stalls hold the grant.
module mux_rr_sel_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic [3:0] ack,
    output logic       busy
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state, state_nx;
    logic [1:0] sel_nx;
    logic [1:0] last_grant, last_grant_nx;
    logic [7:0] beat_cnt, beat_cnt_nx;
    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;

    // Search upward from the channel after the previous winner, wrapping mod 4.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        sel_nx        = sel;
        last_grant_nx = last_grant;
        beat_cnt_nx   = beat_cnt;
        out_valid     = 1'b0;
        ack           = 4'b0000;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nx      = winner;
                    beat_cnt_nx = 8'd0;
                    state_nx    = GRANT;
                end
            end
            GRANT: begin
                busy      = 1'b1;
                out_valid = req[sel];
                if (out_valid && out_ready) begin
                    ack[sel]    = 1'b1;
                    beat_cnt_nx = beat_cnt + 8'd1;
                    if (beat_cnt + 8'd1 == BURST_LIM) begin
                        beat_cnt_nx   = 8'd0;
                        last_grant_nx = sel;
                        state_nx      = IDLE;
                    end
                end else if (!req[sel]) begin
                    // Requester withdrew (after its last beat, or before any): give up the grant.
                    beat_cnt_nx   = 8'd0;
                    last_grant_nx = sel;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 2'b00;
            last_grant <= 2'b11;
            beat_cnt   <= 8'd0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            last_grant <= last_grant_nx;
            beat_cnt   <= beat_cnt_nx;
        end
    end

endmodule
